// File: rtl/rvcpu_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Imported by imem_boot_loader (optional feature macro: IMEM_LOADER_CHECKSUM_EN).
package rvcpu_boot_pkg;

    typedef enum logic [2:0] {
        MAGIC = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } ldr_state_t;

    localparam logic [7:0] LDR_MAGIC     = 8'hA5;
    localparam int         LDR_LEN_BYTES = 2;
    localparam int         LDR_LEN_WIDTH = 8 * LDR_LEN_BYTES;

    // States in which the inter-byte idle timeout is armed.
    function automatic logic ldr_timed(input ldr_state_t s);
        logic timed;
        case (s)
            LEN0, LEN1, DATA, CSUM: timed = 1'b1;
            default:                timed = 1'b0;
        endcase
        return timed;
    endfunction

endpackage

// File: rtl/imem_boot_timeout.sv
// Loadable down-counter measuring idle cycles between accepted bytes.
module imem_boot_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_r;

    // Reload on every accepted byte or while disarmed, otherwise count down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= LOAD_VAL;
        end else if (clear || !run) begin
            cnt_r <= LOAD_VAL;
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // An accepted byte in the expiry cycle wins over the timeout.
    assign expired = run && !clear && (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream boot loader writing little-endian words into IMEM.
// Optional checksum byte after the data is enabled by `define IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
    import rvcpu_boot_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      rx_ready,
    input  logic                      boot_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    output logic                      imem_sel_ldr,
    output logic                      cpu_hold,
    output logic                      done,
    output logic                      err
);

    localparam int         WIDX      = MEM_ADDR_WIDTH - 1;
    localparam logic [31:0] CAP_WORDS = 32'(2 ** (MEM_ADDR_WIDTH - 2));
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam ldr_state_t POST_DATA = CSUM;
`else
    localparam ldr_state_t POST_DATA = DONE;
`endif

    ldr_state_t                state_r, state_nxt_s;
    logic                      we_nxt_s;
    logic                      rx_ready_r, rx_ready_nxt_s;
    logic                      mem_we_r;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_r;
    logic [31:0]               mem_wdata_r;
    logic                      sel_r, sel_nxt_s;
    logic                      hold_r, hold_nxt_s;
    logic                      done_r, done_nxt_s;
    logic                      err_r, err_nxt_s;
    logic [LDR_LEN_WIDTH-1:0]  len_r;
    logic [LDR_LEN_WIDTH-1:0]  len_full_s;
    logic [1:0]                byte_idx_r;
    logic [WIDX-1:0]           word_idx_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]                csum_r;
`endif
    logic                      accept_s;
    logic                      leave_s;
    logic                      last_word_s;
    logic                      too_big_s;
    logic                      expired_s;

    assign accept_s    = rx_valid && rx_ready_r;
    assign leave_s     = boot_req && ((state_r == DONE) || (state_r == ERROR));
    assign len_full_s  = {rx_data, len_r[7:0]};
    assign too_big_s   = {{(32-LDR_LEN_WIDTH){1'b0}}, len_full_s} > CAP_WORDS;
    assign last_word_s = ({{(32-WIDX){1'b0}}, word_idx_r} + 32'd1) ==
                         {{(32-LDR_LEN_WIDTH){1'b0}}, len_r};

    imem_boot_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept_s),
        .run     (ldr_timed(state_r)),
        .expired (expired_s)
    );

    // State and registered outputs; DONE/ERROR flags all switch on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= MAGIC;
            rx_ready_r <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= {MEM_ADDR_WIDTH{1'b0}};
            sel_r      <= 1'b1;
            hold_r     <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            rx_ready_r <= rx_ready_nxt_s;
            mem_we_r   <= we_nxt_s;
            sel_r      <= sel_nxt_s;
            hold_r     <= hold_nxt_s;
            done_r     <= done_nxt_s;
            err_r      <= err_nxt_s;
            if (we_nxt_s) begin
                mem_addr_r <= {word_idx_r[WIDX-2:0], 2'b00};
            end else begin
                mem_addr_r <= mem_addr_r;
            end
        end
    end

    // Next-state decode; mem_we_r marks the write cycle that closes each word.
    always_comb begin
        state_nxt_s = state_r;
        we_nxt_s    = 1'b0;
        case (state_r)
            MAGIC: begin
                if (accept_s && (rx_data == LDR_MAGIC)) begin
                    state_nxt_s = LEN0;
                end else begin
                    state_nxt_s = MAGIC;
                end
            end
            LEN0: begin
                if (accept_s) begin
                    state_nxt_s = LEN1;
                end else if (expired_s) begin
                    state_nxt_s = ERROR;
                end else begin
                    state_nxt_s = LEN0;
                end
            end
            LEN1: begin
                if (accept_s) begin
                    if (too_big_s) begin
                        state_nxt_s = ERROR;
                    end else if (len_full_s == {LDR_LEN_WIDTH{1'b0}}) begin
                        state_nxt_s = POST_DATA;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else if (expired_s) begin
                    state_nxt_s = ERROR;
                end else begin
                    state_nxt_s = LEN1;
                end
            end
            DATA: begin
                if (mem_we_r) begin
                    state_nxt_s = last_word_s ? POST_DATA : DATA;
                end else if (accept_s) begin
                    we_nxt_s    = (byte_idx_r == 2'd3);
                    state_nxt_s = DATA;
                end else if (expired_s) begin
                    state_nxt_s = ERROR;
                end else begin
                    state_nxt_s = DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept_s) begin
                    state_nxt_s = (rx_data == csum_r) ? DONE : ERROR;
                end else if (expired_s) begin
                    state_nxt_s = ERROR;
                end else begin
                    state_nxt_s = CSUM;
                end
            end
`endif
            DONE: begin
                state_nxt_s = boot_req ? MAGIC : DONE;
            end
            ERROR: begin
                state_nxt_s = boot_req ? MAGIC : ERROR;
            end
            default: begin
                state_nxt_s = ERROR;
            end
        endcase
    end

    // Output decode from the upcoming state so flags are registered.
    always_comb begin
        rx_ready_nxt_s = 1'b0;
        sel_nxt_s      = 1'b1;
        hold_nxt_s     = 1'b1;
        done_nxt_s     = 1'b0;
        err_nxt_s      = 1'b0;
        case (state_nxt_s)
            MAGIC, LEN0, LEN1, CSUM: rx_ready_nxt_s = 1'b1;
            DATA:                    rx_ready_nxt_s = !we_nxt_s;
            DONE: begin
                sel_nxt_s  = 1'b0;
                hold_nxt_s = 1'b0;
                done_nxt_s = 1'b1;
            end
            ERROR:   err_nxt_s = 1'b1;
            default: err_nxt_s = 1'b1;
        endcase
    end

    // Length capture, byte packing and word/byte counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wdata_r <= 32'h0000_0000;
            len_r       <= {LDR_LEN_WIDTH{1'b0}};
            byte_idx_r  <= 2'd0;
            word_idx_r  <= {WIDX{1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r      <= 8'h00;
`endif
        end else if (leave_s) begin
            len_r       <= {LDR_LEN_WIDTH{1'b0}};
            byte_idx_r  <= 2'd0;
            word_idx_r  <= {WIDX{1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r      <= 8'h00;
`endif
        end else begin
            if (accept_s && (state_r == LEN0)) begin
                len_r[7:0] <= rx_data;
            end
            if (accept_s && (state_r == LEN1)) begin
                len_r[15:8] <= rx_data;
            end
            if (accept_s && (state_r == DATA)) begin
                mem_wdata_r[{byte_idx_r, 3'b000} +: 8] <= rx_data;
                byte_idx_r <= byte_idx_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_r     <= csum_r ^ rx_data;
`endif
            end
            if (mem_we_r) begin
                word_idx_r <= word_idx_r + WIDX'(1);
            end
        end
    end

    assign rx_ready     = rx_ready_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign imem_sel_ldr = sel_r;
    assign cpu_hold     = hold_r;
    assign done         = done_r;
    assign err          = err_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected IMEM writes are queued at stimulus time
// and popped by a monitor on every mem_we; status flags are checked at frame boundaries.
module tb_imem_boot_loader;

    localparam int AW = 10;
    localparam int TO = 40;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          boot_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          imem_sel_ldr;
    logic          cpu_hold;
    logic          done;
    logic          err;

    int   n_checks = 0;
    int   n_fail   = 0;
    wr_t  exp_q[$];
    logic [7:0] data_q[$];

    imem_boot_loader #(.MEM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .boot_req(boot_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .imem_sel_ldr(imem_sel_ldr), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%03h data 0x%08h, none expected",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
                check("rx_ready_in_write", 32'(rx_ready), 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("rx_accept_timeout", 32'(n), 32'd0);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic make_data(input int n_words);
        data_q.delete();
        for (int i = 0; i < 4 * n_words; i++) data_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference: word i is bytes 4i..4i+3, first byte in the low lane, written at byte addr 4i.
    task automatic expect_words(input int n_words);
        wr_t e;
        for (int i = 0; i < n_words; i++) begin
            e.addr = AW'(4 * i);
            e.data = 32'(data_q[4*i]) + (32'(data_q[4*i+1]) << 8) +
                     (32'(data_q[4*i+2]) << 16) + (32'(data_q[4*i+3]) << 24);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input int n_words, input bit bad_chk, input bit gaps);
        logic [7:0] x;
        x = 8'h00;
        send_byte(8'hA5);
        send_byte(8'(n_words % 256));
        send_byte(8'(n_words / 256));
        foreach (data_q[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(data_q[i]);
            x = x ^ data_q[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_chk ? (x ^ 8'h01) : x);
`else
        if (bad_chk) x = 8'h00;
`endif
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!done && !err && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("wait_end_timeout", 32'(n), 32'd0);
    endtask

    task automatic check_done(input string nm);
        check({nm, "_done"}, 32'(done), 32'd1);
        check({nm, "_err"}, 32'(err), 32'd0);
        check({nm, "_hold"}, 32'(cpu_hold), 32'd0);
        check({nm, "_sel"}, 32'(imem_sel_ldr), 32'd0);
        check({nm, "_rdy"}, 32'(rx_ready), 32'd0);
    endtask

    task automatic check_err(input string nm);
        check({nm, "_err"}, 32'(err), 32'd1);
        check({nm, "_done"}, 32'(done), 32'd0);
        check({nm, "_hold"}, 32'(cpu_hold), 32'd1);
        check({nm, "_sel"}, 32'(imem_sel_ldr), 32'd1);
        check({nm, "_rdy"}, 32'(rx_ready), 32'd0);
    endtask

    task automatic do_boot_req(input string nm);
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
        check({nm, "_hold"}, 32'(cpu_hold), 32'd1);
        check({nm, "_sel"}, 32'(imem_sel_ldr), 32'd1);
        check({nm, "_done"}, 32'(done), 32'd0);
        check({nm, "_err"}, 32'(err), 32'd0);
        check({nm, "_rdy"}, 32'(rx_ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_rdy"}, 32'(rx_ready), 32'd1);
        check({nm, "_we"}, 32'(mem_we), 32'd0);
        check({nm, "_addr"}, 32'(mem_addr), 32'd0);
        check({nm, "_wdata"}, mem_wdata, 32'd0);
        check({nm, "_sel"}, 32'(imem_sel_ldr), 32'd1);
        check({nm, "_hold"}, 32'(cpu_hold), 32'd1);
        check({nm, "_done"}, 32'(done), 32'd0);
        check({nm, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; boot_req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Frame 1 with fixed data.
        data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        expect_words(2);
        send_frame(2, 1'b0, 1'b0);
        wait_end();
        check_done("frame1");
        do_boot_req("boot1");

        // boot_req outside DONE/ERROR is ignored; noise bytes are dropped in MAGIC.
        do_boot_req("boot_idle");
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        repeat (2) @(negedge clk);
        check("noise_rdy", 32'(rx_ready), 32'd1);
        check("noise_done", 32'(done), 32'd0);
        check("noise_err", 32'(err), 32'd0);
        expect_words(2);
        send_frame(2, 1'b0, 1'b1);
        wait_end();
        check_done("noise_frame1");
        do_boot_req("boot2");

        // Oversized length: error right after LEN1, no writes.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        check_err("too_big");
        do_boot_req("boot3");

        // Exactly full capacity loads.
        make_data(256);
        expect_words(256);
        send_frame(256, 1'b0, 1'b0);
        wait_end();
        check_done("cap_full");
        do_boot_req("boot4");

        // Empty image.
        data_q.delete();
        send_frame(0, 1'b0, 1'b0);
        wait_end();
        check_done("empty");
        do_boot_req("boot5");

        // Timeout mid word: no partial write.
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        repeat (TO - 1) @(negedge clk);
        check("timeout_early_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        check_err("timeout");
        do_boot_req("boot6");

`ifdef IMEM_LOADER_CHECKSUM_EN
        data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        expect_words(2);
        send_frame(2, 1'b1, 1'b0);
        wait_end();
        check_err("bad_chk");
        do_boot_req("boot7");
`endif

        // Random frames.
        for (int k = 0; k < 4; k++) begin
            int nw;
            nw = $urandom_range(1, 6);
            make_data(nw);
            expect_words(nw);
            send_frame(nw, 1'b0, 1'b1);
            wait_end();
            check_done("rand");
            do_boot_req("boot_rand");
        end

        // Reset during word 1: word 0 stays written, then a fresh frame starts at 0.
        make_data(2);
        expect_words(1);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        for (int i = 0; i < 6; i++) send_byte(data_q[i]);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        make_data(2);
        expect_words(2);
        send_frame(2, 1'b0, 1'b0);
        wait_end();
        check_done("after_rst");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
